// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: port ids, per-port state encoding and constants shared by the dmem arbiter
package dmem_arb_pkg;
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} port_state_e;
  localparam int MAX_DATA_WIDTH = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] RDATA_ZERO = '0;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, last winner loses the next tie, port 1 counts as last after reset
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_gnt_q, last_gnt_d;
  always_comb begin
    gnt[PORT_CPU] = req[PORT_CPU] & (~req[PORT_DBG] | last_gnt_q);
    gnt[PORT_DBG] = req[PORT_DBG] & (~req[PORT_CPU] | ~last_gnt_q);
    last_gnt_d = |gnt ? gnt[PORT_DBG] : last_gnt_q;
  end
  always_ff @(posedge clk) last_gnt_q <= reset ? 1'b1 : last_gnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the cpu and debug ports with cpu stall tracking
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err_misalign,
  output logic [CNT_WIDTH-1:0]  stall_count
);
  port_state_e state_q [2];
  port_state_e state_d [2];
  logic [1:0] req, gnt, zero_q, zero_d;
  logic sel, sel_we, mis, unused_ok;
  logic [31:0] sel_addr;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  always_comb begin
    req[PORT_CPU] = ~reset & cpu_req & (state_q[PORT_CPU] == IDLE);
    req[PORT_DBG] = ~reset & dbg_req & (state_q[PORT_DBG] == IDLE);
  end
  rr_arb2 u_rr_arb2 (.clk(clk), .reset(reset), .req(req), .gnt(gnt));
  always_comb begin
    sel = gnt[PORT_DBG];
    sel_addr = sel ? dbg_addr : cpu_addr;
    sel_we = sel ? dbg_we : cpu_we;
    mis = |gnt & |sel_addr[1:0];
    mem_en = |gnt & ~mis;
    mem_we = mem_en & sel_we;
    mem_addr = |gnt ? sel_addr[ADDR_WIDTH+1:2] : '0;
    mem_wdata = |gnt ? (sel ? dbg_wdata : cpu_wdata) : '0;
    err_misalign = mis;
    cpu_gnt = gnt[PORT_CPU];
    dbg_gnt = gnt[PORT_DBG];
    cpu_rvalid = ~reset & (state_q[PORT_CPU] == RD_WAIT);
    dbg_rvalid = ~reset & (state_q[PORT_DBG] == RD_WAIT);
    cpu_rdata = (cpu_rvalid & ~zero_q[PORT_CPU]) ? mem_rdata : RDATA_ZERO[DATA_WIDTH-1:0];
    dbg_rdata = (dbg_rvalid & ~zero_q[PORT_DBG]) ? mem_rdata : RDATA_ZERO[DATA_WIDTH-1:0];
    cpu_stall = ~reset & cpu_req & ~((cpu_gnt & cpu_we) | cpu_rvalid);
    state_d[PORT_CPU] = (gnt[PORT_CPU] & ~cpu_we) ? RD_WAIT : IDLE;
    state_d[PORT_DBG] = (gnt[PORT_DBG] & ~dbg_we) ? RD_WAIT : IDLE;
    zero_d = gnt & {2{mis}};
    stall_count_d = (cpu_stall & ~&stall_count_q) ? stall_count_q + CNT_WIDTH'(1) : stall_count_q;
  end
  always_ff @(posedge clk) begin
    state_q[PORT_CPU] <= reset ? IDLE : state_d[PORT_CPU];
    state_q[PORT_DBG] <= reset ? IDLE : state_d[PORT_DBG];
    zero_q <= reset ? 2'b00 : zero_d;
    stall_count_q <= reset ? '0 : stall_count_d;
  end
  assign unused_ok = ^sel_addr[31:ADDR_WIDTH+2];
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and randomized traffic against a behavioural model
module tb_dmem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NV = 15;
  localparam int CMAX = 15;
  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic cg, cv; logic [31:0] crd; logic cs;
    logic dg, dv; logic [31:0] drd;
    logic en, err; logic [AW-1:0] ma;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_wdata, mem_rdata;
  logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid, mem_en, mem_we, err_misalign;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] stall_count;
  logic [31:0] dmem [2048];
  logic [31:0] mm [2048];
  logic [1:0] m_pend;
  logic [31:0] m_pdata [2];
  int m_last, m_cnt;
  int checks = 0;
  int errors = 0;
  vec_t tbl [NV];
  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_misalign(err_misalign), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[mem_addr] = mem_wdata;
      else mem_rdata <= dmem[mem_addr];
    end
  end
  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic drive(input logic cr, cw, input logic [31:0] ca, cd, input logic dr, dw, input logic [31:0] da, dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    drive(1, 0, 32'h20, 0, 1, 0, 32'h10, 0);
    tick;
    tick;
    #1;
    chk1("rst cpu_gnt", cpu_gnt, 0);
    chk1("rst dbg_gnt", dbg_gnt, 0);
    chk1("rst cpu_rvalid", cpu_rvalid, 0);
    chk1("rst dbg_rvalid", dbg_rvalid, 0);
    chk1("rst cpu_stall", cpu_stall, 0);
    chk1("rst mem_en", mem_en, 0);
    chk1("rst mem_we", mem_we, 0);
    chk1("rst err_misalign", err_misalign, 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst stall_count", 32'(stall_count), 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_pend = 2'b00;
    m_last = 1;
    m_cnt = 0;
  endtask
  task automatic run_random(input int n);
    logic [1:0] act, awe, g, np;
    logic [31:0] aad [2];
    logic [31:0] adt [2];
    logic [31:0] ga;
    logic mis, en, cs;
    int gp, idx;
    act = 2'b00;
    awe = 2'b00;
    aad = '{0, 0};
    adt = '{0, 0};
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 2) != 0) begin
          act[p] = 1'b1;
          awe[p] = 1'($urandom_range(0, 1));
          aad[p] = (32'($urandom_range(0, 3)) << 13) | (32'(256 + $urandom_range(0, 15)) << 2)
                 | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
          adt[p] = $urandom;
        end
      end
      drive(act[0], awe[0], aad[0], adt[0], act[1], awe[1], aad[1], adt[1]);
      g[0] = act[0] & ~m_pend[0] & (~(act[1] & ~m_pend[1]) | (m_last == 1));
      g[1] = act[1] & ~m_pend[1] & ~g[0];
      gp = g[1] ? 1 : 0;
      ga = aad[gp];
      mis = (|g) && (ga[1:0] != 2'b00);
      en = (|g) && !mis;
      idx = int'(ga[12:2]);
      cs = act[0] && !((g[0] && awe[0]) || m_pend[0]);
      #1;
      chk1("rnd cpu_gnt", cpu_gnt, g[0]);
      chk1("rnd dbg_gnt", dbg_gnt, g[1]);
      chk1("rnd cpu_rvalid", cpu_rvalid, m_pend[0]);
      chk1("rnd dbg_rvalid", dbg_rvalid, m_pend[1]);
      chk("rnd cpu_rdata", cpu_rdata, m_pend[0] ? m_pdata[0] : 32'd0);
      chk("rnd dbg_rdata", dbg_rdata, m_pend[1] ? m_pdata[1] : 32'd0);
      chk1("rnd cpu_stall", cpu_stall, cs);
      chk1("rnd mem_en", mem_en, en);
      chk1("rnd err_misalign", err_misalign, mis);
      chk("rnd stall_count", 32'(stall_count), 32'(m_cnt));
      if (en) begin
        chk1("rnd mem_we", mem_we, awe[gp]);
        chk("rnd mem_addr", 32'(mem_addr), 32'(idx));
        if (awe[gp]) chk("rnd mem_wdata", mem_wdata, adt[gp]);
      end
      np = 2'b00;
      if (|g) begin
        m_last = gp;
        if (!awe[gp]) begin
          np[gp] = 1'b1;
          m_pdata[gp] = mis ? 32'd0 : mm[idx];
        end else if (!mis) mm[idx] = adt[gp];
      end
      if (cs && m_cnt < CMAX) m_cnt++;
      act = act & ~(m_pend | (g & awe));
      m_pend = np;
      tick;
    end
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) begin
      dmem[i] = init_word(i);
      mm[i] = init_word(i);
    end
    tbl[0]  = '{1, 1, 'h20, 'h000C08EB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 8};
    tbl[1]  = '{1, 0, 'h20, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 8};
    tbl[2]  = '{1, 0, 'h20, 0, 0, 0, 0, 0, 0, 1, 'h000C08EB, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 'h22, 'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{1, 0, 'h23, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{1, 0, 'h23, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 'h20, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 8};
    tbl[7]  = '{1, 0, 'h20, 0, 0, 0, 0, 0, 0, 1, 'h000C08EB, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4};
    tbl[9]  = '{1, 1, 'h30, 'h55, 1, 0, 'h10, 0, 1, 0, 0, 0, 0, 1, 'hA5A50004, 1, 0, 12};
    tbl[10] = '{1, 0, 'h30, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 12};
    tbl[11] = '{1, 0, 'h30, 0, 0, 0, 0, 0, 0, 1, 'h55, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 'h2020, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 8};
    tbl[13] = '{1, 0, 'h2020, 0, 0, 0, 0, 0, 0, 1, 'h000C08EB, 0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_reset;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      #1;
      chk1($sformatf("v%0d cpu_gnt", i), cpu_gnt, tbl[i].cg);
      chk1($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, tbl[i].cv);
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].crd);
      chk1($sformatf("v%0d cpu_stall", i), cpu_stall, tbl[i].cs);
      chk1($sformatf("v%0d dbg_gnt", i), dbg_gnt, tbl[i].dg);
      chk1($sformatf("v%0d dbg_rvalid", i), dbg_rvalid, tbl[i].dv);
      chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, tbl[i].drd);
      chk1($sformatf("v%0d mem_en", i), mem_en, tbl[i].en);
      chk1($sformatf("v%0d err_misalign", i), err_misalign, tbl[i].err);
      if (tbl[i].en) begin
        chk1($sformatf("v%0d mem_we", i), mem_we, tbl[i].cg ? tbl[i].cw : tbl[i].dw);
        chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ma));
        if (tbl[i].cg ? tbl[i].cw : tbl[i].dw)
          chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].cg ? tbl[i].cd : tbl[i].dd);
      end
      tick;
    end
    chk("t1 dmem word 8", dmem[8], 32'h000C08EB);
    chk("t4 dmem word 12", dmem[12], 32'h55);
    chk("tbl stall_count", 32'(stall_count), 5);
    do_reset;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 32'h40 + 32'(4 * k), 32'(k), 1, 1, 32'h80, 32'(100 + k));
      #1;
      chk1($sformatf("t3 c%0d cpu_gnt", k), cpu_gnt, (k % 2) == 0);
      chk1($sformatf("t3 c%0d dbg_gnt", k), dbg_gnt, (k % 2) == 1);
      chk1($sformatf("t3 c%0d mem_en", k), mem_en, 1);
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3 stall_count", 32'(stall_count), 3);
    tick;
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
    #1;
    chk1("t6 dbg_gnt", dbg_gnt, 1);
    tick;
    reset = 1'b1;
    drive(1, 0, 32'h20, 0, 1, 0, 32'h10, 0);
    #1;
    chk1("t6 rst dbg_rvalid", dbg_rvalid, 0);
    chk("t6 rst dbg_rdata", dbg_rdata, 0);
    chk1("t6 rst cpu_gnt", cpu_gnt, 0);
    chk1("t6 rst dbg_gnt", dbg_gnt, 0);
    chk1("t6 rst cpu_stall", cpu_stall, 0);
    chk1("t6 rst mem_en", mem_en, 0);
    tick;
    reset = 1'b0;
    #1;
    chk1("t6 post dbg_rvalid", dbg_rvalid, 0);
    chk("t6 post stall_count", 32'(stall_count), 0);
    chk1("t6 tie cpu_gnt", cpu_gnt, 1);
    chk1("t6 tie dbg_gnt", dbg_gnt, 0);
    tick;
    #1;
    chk1("t6 next cpu_rvalid", cpu_rvalid, 1);
    chk1("t6 next dbg_gnt", dbg_gnt, 1);
    tick;
    do_reset;
    run_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
